// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART byte receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   // Whole clock cycles per serial bit; the remainder is deliberately dropped.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Byte-stream interface between the UART receiver and its consumer (parseUart).
interface uart_byte_rx_if;

   logic [7:0] data_in;
   logic       data_rdy;
   logic       frame_err;
   logic       busy;

   modport master (
      output data_in,
      output data_rdy,
      output frame_err,
      output busy
   );

   modport slave (
      input data_in,
      input data_rdy,
      input frame_err,
      input busy
   );

endinterface

// File: rtl/uart_byte_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Resample the asynchronous input twice; reset parks both flops at the idle level.
   always_ff @(posedge clk) begin
      if (!rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: recovers bytes from rx and strobes them out one cycle at a time.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115_200
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rx,
   uart_byte_rx_if.master bus
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int MID          = CLKS_PER_BIT / 2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_byte_rx: CLKS_PER_BIT must be at least 4");
   end

   uart_rx_state_t   state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic [7:0]       data_reg;
   logic             rdy_reg;
   logic             err_reg;
   logic             rx_s;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // Frame FSM: find the start edge, confirm it at half a bit, then sample each bit at its centre.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         data_reg <= '0;
         rdy_reg  <= 1'b0;
         err_reg  <= 1'b0;
      end else begin
         rdy_reg <= 1'b0;
         err_reg <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rx_s) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == CNT_MID) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     data_reg <= shreg;
                     rdy_reg  <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     err_reg <= 1'b1;
                     state   <= BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BREAK: begin
               cnt <= '0;
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.data_in   = data_reg;
   assign bus.data_rdy  = rdy_reg;
   assign bus.frame_err = err_reg;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: drives serial frames and scoreboards the byte stream.
module tb_uart_byte_rx;

   localparam int CLK_HZ     = 1_000_000;
   localparam int BAUD       = 100_000;
   localparam int BIT_CYCLES = CLK_HZ / BAUD;
   localparam int LATENCY    = 2 + BIT_CYCLES / 2 + 9 * BIT_CYCLES + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx  = 1'b1;

   uart_byte_rx_if bus ();

   uart_byte_rx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rx  (rx),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] data;
      logic       is_err;
      int         due;
   } exp_t;

   exp_t       exp_q[$];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] last_byte = 8'h00;

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used to timestamp expected and observed pulses.
   always @(posedge clk) cyc <= cyc + 1;

   // Safety net in case the run stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Sends one 8N1 frame, starting right after a posedge; records what the receiver must report.
   task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      exp_t e;
      frame    = {stop_bit, b, 1'b0};
      e.data   = b;
      e.is_err = !stop_bit;
      e.due    = cyc + LATENCY;
      exp_q.push_back(e);
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         repeat (BIT_CYCLES) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_line(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation in kind, time and data.
   always @(negedge clk) begin
      exp_t e;
      if (rst && (bus.data_rdy || bus.frame_err)) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_pulse", {30'd0, bus.frame_err, bus.data_rdy}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_output("pulse_kind", {30'd0, bus.frame_err, bus.data_rdy},
                         e.is_err ? 32'd2 : 32'd1);
            check_output("pulse_cycle", cyc, e.due);
            if (e.is_err) begin
               check_output("data_held_on_err", {24'd0, bus.data_in}, {24'd0, last_byte});
            end else begin
               check_output("data_in", {24'd0, bus.data_in}, {24'd0, e.data});
               last_byte = e.data;
            end
         end
      end
   end

   initial begin
      logic [9:0] partial;

      // Reset with the line idle.
      rst = 1'b0;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_data_in", {24'd0, bus.data_in}, 32'd0);
      check_output("reset_data_rdy", {31'd0, bus.data_rdy}, 32'd0);
      check_output("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
      rst = 1'b1;
      idle_line(10);

      // Single byte.
      apply_stimulus(8'h55, 1'b1);
      idle_line(15);

      // Back-to-back burst with no idle gap.
      for (int b = 1; b <= 8'h15; b++) begin
         apply_stimulus(8'(b), 1'b1);
      end
      idle_line(15);

      // Short low glitch must be rejected.
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle_line(12);
      check_output("glitch_busy", {31'd0, bus.busy}, 32'd0);
      apply_stimulus(8'hA3, 1'b1);
      idle_line(15);

      // Framing error followed by a long break, then a normal byte.
      apply_stimulus(8'hF0, 1'b0);
      rx = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      idle_line(20);
      check_output("break_busy", {31'd0, bus.busy}, 32'd0);
      apply_stimulus(8'h3C, 1'b1);
      idle_line(15);

      // Random bytes with random idle gaps.
      for (int n = 0; n < 16; n++) begin
         apply_stimulus(8'($urandom_range(0, 255)), 1'b1);
         idle_line($urandom_range(0, 25));
      end
      idle_line(15);

      // Reset in the middle of bit 4 of 0x81: start + bits 0..3, then half of bit 4.
      partial = {1'b1, 8'h81, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx = partial[i];
         repeat (BIT_CYCLES) @(posedge clk);
         #1;
      end
      rx = partial[5];
      repeat (BIT_CYCLES / 2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rx = 1'b1;
      check_output("midreset_data_in", {24'd0, bus.data_in}, 32'd0);
      check_output("midreset_busy", {31'd0, bus.busy}, 32'd0);
      last_byte = 8'h00;
      rst = 1'b1;
      idle_line(20);
      check_output("post_reset_busy", {31'd0, bus.busy}, 32'd0);
      apply_stimulus(8'h7E, 1'b1);
      idle_line(15);

      // Let any outstanding expectations drain, bounded.
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      #1;
      check_output("queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
